// File: rtl/ahbmgrarb.sv
// Two-manager AHB-Lite arbiter in front of the uncore subordinate port.
// Owner passes through combinationally; a non-owner's address phase is buffered and replayed.
module ahbmgrarb #(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned AHBW    = 32,
  parameter int unsigned XLEN    = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [PA_BITS-1:0]  M0HADDR,
  input  logic                M0HWRITE,
  input  logic [2:0]          M0HSIZE,
  input  logic [2:0]          M0HBURST,
  input  logic [3:0]          M0HPROT,
  input  logic [1:0]          M0HTRANS,
  input  logic                M0HMASTLOCK,
  input  logic [AHBW-1:0]     M0HWDATA,
  input  logic [XLEN/8-1:0]   M0HWSTRB,
  output logic                M0HREADY,
  output logic                M0HRESP,
  output logic [AHBW-1:0]     M0HRDATA,
  input  logic [PA_BITS-1:0]  M1HADDR,
  input  logic                M1HWRITE,
  input  logic [2:0]          M1HSIZE,
  input  logic [2:0]          M1HBURST,
  input  logic [3:0]          M1HPROT,
  input  logic [1:0]          M1HTRANS,
  input  logic                M1HMASTLOCK,
  input  logic [AHBW-1:0]     M1HWDATA,
  input  logic [XLEN/8-1:0]   M1HWSTRB,
  output logic                M1HREADY,
  output logic                M1HRESP,
  output logic [AHBW-1:0]     M1HRDATA,
  output logic [PA_BITS-1:0]  HADDR,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic [1:0]          HTRANS,
  output logic                HMASTLOCK,
  output logic [AHBW-1:0]     HWDATA,
  output logic [XLEN/8-1:0]   HWSTRB,
  input  logic [AHBW-1:0]     HRDATA,
  input  logic                HREADY,
  input  logic                HRESP,
  output logic                HGRANT
);

  typedef struct packed {
    logic [PA_BITS-1:0] addr;
    logic               write;
    logic [2:0]         size;
    logic [2:0]         burst;
    logic [3:0]         prot;
    logic               lock;
  } ctl_t;

  logic       owner_q, data_valid_q, data_owner_q;
  logic [1:0] held_q;
  ctl_t       cap_q [2];

  ctl_t       live [2];
  logic [1:0] trans [2];
  logic       switch_own, sel;
  ctl_t       sub;
  logic [1:0] sub_trans;
  logic [1:0] mready;
  logic [1:0] capture;

  always_comb begin
    live[0]  = '{addr: M0HADDR, write: M0HWRITE, size: M0HSIZE, burst: M0HBURST,
                 prot: M0HPROT, lock: M0HMASTLOCK};
    live[1]  = '{addr: M1HADDR, write: M1HWRITE, size: M1HSIZE, burst: M1HBURST,
                 prot: M1HPROT, lock: M1HMASTLOCK};
    trans[0] = M0HTRANS;
    trans[1] = M1HTRANS;
  end

  // Hand over only at a NONSEQ/IDLE boundary of an unlocked owner (HTRANS[0]=1 is SEQ/BUSY).
  always_comb begin
    switch_own = HREADY & held_q[~owner_q] & ~held_q[owner_q] & ~trans[owner_q][0]
                 & ~live[owner_q].lock;
    sel        = switch_own ? ~owner_q : owner_q;
    if (held_q[sel]) begin
      sub       = cap_q[sel];
      sub_trans = 2'b10;
    end else begin
      sub       = live[sel];
      sub_trans = trans[sel];
    end
  end

  always_comb begin
    mready  = '1;
    capture = '0;
    for (int x = 0; x < 2; x++) begin
      if (data_valid_q && (data_owner_q == 1'(x))) begin
        mready[x] = HREADY;
      end else if (held_q[x]) begin
        mready[x] = 1'b0;
      end else if ((owner_q == 1'(x)) && !switch_own) begin
        mready[x] = HREADY;
      end else begin
        mready[x] = 1'b1;
      end
      // A manager not driving the subordinate live this cycle gets its request buffered.
      capture[x] = mready[x] & trans[x][1] & (sel != 1'(x));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q      <= 1'b0;
      data_valid_q <= 1'b0;
      data_owner_q <= 1'b0;
      held_q       <= '0;
      cap_q[0]     <= '0;
      cap_q[1]     <= '0;
    end else begin
      owner_q <= sel;
      for (int x = 0; x < 2; x++) begin
        if (capture[x]) begin
          held_q[x] <= 1'b1;
          cap_q[x]  <= live[x];
        end
      end
      if (HREADY) begin
        if (sub_trans[1]) begin
          data_valid_q <= 1'b1;
          data_owner_q <= sel;
          if (held_q[sel]) held_q[sel] <= 1'b0;
        end else begin
          data_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    HADDR     = sub.addr;
    HWRITE    = sub.write;
    HSIZE     = sub.size;
    HBURST    = sub.burst;
    HPROT     = sub.prot;
    HMASTLOCK = sub.lock;
    HTRANS    = sub_trans;
    HWDATA    = data_owner_q ? M1HWDATA : M0HWDATA;
    HWSTRB    = data_owner_q ? M1HWSTRB : M0HWSTRB;
    HGRANT    = sel;
    M0HREADY  = mready[0];
    M1HREADY  = mready[1];
    M0HRESP   = HRESP & data_valid_q & ~data_owner_q;
    M1HRESP   = HRESP & data_valid_q & data_owner_q;
    M0HRDATA  = HRDATA;
    M1HRDATA  = HRDATA;
  end

endmodule

// File: tb/tb_ahbmgrarb.sv
// Directed vector bench for ahbmgrarb: one table row per clock cycle plus a reset sequence.
module tb_ahbmgrarb;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [31:0] WD0 = 32'h0bad_f00d;
  localparam logic [31:0] WD1 = 32'hdead_beef;

  logic        HCLK, HRESETn;
  logic [31:0] M0HADDR, M1HADDR, M0HWDATA, M1HWDATA, M0HRDATA, M1HRDATA;
  logic        M0HWRITE, M1HWRITE, M0HMASTLOCK, M1HMASTLOCK;
  logic [2:0]  M0HSIZE, M0HBURST, M1HSIZE, M1HBURST;
  logic [3:0]  M0HPROT, M1HPROT, M0HWSTRB, M1HWSTRB;
  logic [1:0]  M0HTRANS, M1HTRANS;
  logic        M0HREADY, M1HREADY, M0HRESP, M1HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, HGRANT;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT, HWSTRB;
  logic [1:0]  HTRANS;

  int passed = 0;
  int total  = 0;

  ahbmgrarb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0HADDR(M0HADDR), .M0HWRITE(M0HWRITE), .M0HSIZE(M0HSIZE), .M0HBURST(M0HBURST),
    .M0HPROT(M0HPROT), .M0HTRANS(M0HTRANS), .M0HMASTLOCK(M0HMASTLOCK),
    .M0HWDATA(M0HWDATA), .M0HWSTRB(M0HWSTRB), .M0HREADY(M0HREADY), .M0HRESP(M0HRESP),
    .M0HRDATA(M0HRDATA),
    .M1HADDR(M1HADDR), .M1HWRITE(M1HWRITE), .M1HSIZE(M1HSIZE), .M1HBURST(M1HBURST),
    .M1HPROT(M1HPROT), .M1HTRANS(M1HTRANS), .M1HMASTLOCK(M1HMASTLOCK),
    .M1HWDATA(M1HWDATA), .M1HWSTRB(M1HWSTRB), .M1HREADY(M1HREADY), .M1HRESP(M1HRESP),
    .M1HRDATA(M1HRDATA),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  m0t;
    logic [31:0] m0a;
    logic        m0w;
    logic        m0l;
    logic [1:0]  m1t;
    logic [31:0] m1a;
    logic        m1w;
    logic        m1l;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
    logic [1:0]  et;
    logic [31:0] ea;
    logic        ew;
    logic        el;
    logic        er0;
    logic        er1;
    logic        ep0;
    logic        ep1;
    logic        eg;
    logic        edo;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
  endtask

  task automatic drive(input vec_t v);
    M0HTRANS = v.m0t; M0HADDR = v.m0a; M0HWRITE = v.m0w; M0HMASTLOCK = v.m0l;
    M1HTRANS = v.m1t; M1HADDR = v.m1a; M1HWRITE = v.m1w; M1HMASTLOCK = v.m1l;
    HREADY = v.rdy; HRESP = v.resp; HRDATA = v.rd;
  endtask

  task automatic check(input vec_t v, input int i);
    chk("HTRANS", i, 32'(HTRANS), 32'(v.et));
    chk("HADDR", i, HADDR, v.ea);
    chk("HWRITE", i, 32'(HWRITE), 32'(v.ew));
    chk("HMASTLOCK", i, 32'(HMASTLOCK), 32'(v.el));
    chk("M0HREADY", i, 32'(M0HREADY), 32'(v.er0));
    chk("M1HREADY", i, 32'(M1HREADY), 32'(v.er1));
    chk("M0HRESP", i, 32'(M0HRESP), 32'(v.ep0));
    chk("M1HRESP", i, 32'(M1HRESP), 32'(v.ep1));
    chk("HGRANT", i, 32'(HGRANT), 32'(v.eg));
    chk("HWDATA", i, HWDATA, v.edo ? WD1 : WD0);
    chk("HWSTRB", i, 32'(HWSTRB), v.edo ? 32'hc : 32'h3);
    chk("M0HRDATA", i, M0HRDATA, v.rd);
    chk("M1HRDATA", i, M1HRDATA, v.rd);
  endtask

  initial begin
    // m0: t addr w l | m1: t addr w l | rdy resp rdata | exp: t addr w l r0 r1 p0 p1 g do
    // M0 alone, single read
    vecs[0]  = '{NSQ, 32'h8000_0000, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h8000_0000, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0,      IDL, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[2]  = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 32'h1234, IDL, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    // M1 write captured, replayed next cycle
    vecs[3]  = '{IDL, 0, 0, 0, NSQ, 32'h1000_0000, 1, 0, 1, 0, 0,
                 IDL, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h1000_0000, 1, 0, 1, 0, 0, 0, 1, 0};
    vecs[5]  = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0,      IDL, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    vecs[6]  = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,      IDL, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    // M0 INCR4 (first beat buffered), M1 NONSEQ at beat 2, replayed read gets ERROR
    vecs[7]  = '{NSQ, 32'h2000_0000, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 IDL, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[8]  = '{SQ, 32'h2000_0004, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h2000_0000, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[9]  = '{SQ, 32'h2000_0004, 0, 0, NSQ, 32'h3000_0000, 0, 0, 1, 0, 0,
                 SQ, 32'h2000_0004, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{SQ, 32'h2000_0008, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 SQ, 32'h2000_0008, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{SQ, 32'h2000_000c, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 SQ, 32'h2000_000c, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h3000_0000, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[13] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 0, 1, 0,      IDL, 0, 0, 0, 1, 0, 0, 1, 1, 1};
    vecs[14] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 1, 32'h5555, IDL, 0, 0, 0, 1, 1, 0, 1, 1, 1};
    // M0 locked pair holds off a buffered M1 request
    vecs[15] = '{NSQ, 32'h5000_0000, 1, 1, IDL, 0, 0, 0, 1, 0, 0,
                 IDL, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[16] = '{NSQ, 32'h5000_0004, 1, 1, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h5000_0000, 1, 1, 0, 1, 0, 0, 0, 1};
    vecs[17] = '{NSQ, 32'h5000_0004, 1, 1, NSQ, 32'h6000_0000, 0, 0, 1, 0, 0,
                 NSQ, 32'h5000_0004, 1, 1, 1, 1, 0, 0, 0, 0};
    vecs[18] = '{IDL, 0, 0, 1, IDL, 0, 0, 0, 1, 0, 0,      IDL, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    vecs[19] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h6000_0000, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[20] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 32'ha5a5, IDL, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    // Both request on an idle bus: owner M1 keeps the grant, M0 follows
    vecs[21] = '{NSQ, 32'h7000_0000, 0, 0, NSQ, 32'h7100_0000, 1, 0, 1, 0, 0,
                 NSQ, 32'h7100_0000, 1, 0, 1, 1, 0, 0, 1, 1};
    vecs[22] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,
                 NSQ, 32'h7000_0000, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[23] = '{IDL, 0, 0, 0, IDL, 0, 0, 0, 1, 0, 0,      IDL, 0, 0, 0, 1, 1, 0, 0, 0, 0};

    M0HSIZE = 3'd2; M0HBURST = 3'd3; M0HPROT = 4'h3; M0HWDATA = WD0; M0HWSTRB = 4'h3;
    M1HSIZE = 3'd2; M1HBURST = 3'd0; M1HPROT = 4'h1; M1HWDATA = WD1; M1HWSTRB = 4'hc;
    M0HTRANS = NSQ; M0HADDR = 32'h8000_0000; M0HWRITE = 1'b0; M0HMASTLOCK = 1'b0;
    M1HTRANS = IDL; M1HADDR = '0; M1HWRITE = 1'b0; M1HMASTLOCK = 1'b0;
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = '0;
    HRESETn = 1'b0;

    // Outputs during reset
    #2;
    chk("rst M0HREADY", 0, 32'(M0HREADY), 32'(0));
    chk("rst M1HREADY", 0, 32'(M1HREADY), 32'(1));
    chk("rst M0HRESP", 0, 32'(M0HRESP), 32'(0));
    chk("rst M1HRESP", 0, 32'(M1HRESP), 32'(0));
    chk("rst HTRANS", 0, 32'(HTRANS), 32'(NSQ));
    chk("rst HADDR", 0, HADDR, 32'h8000_0000);
    chk("rst HGRANT", 0, 32'(HGRANT), 32'(0));
    HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i]);
      #2;
      check(vecs[i], i);
      @(posedge HCLK);
      #1;
    end

    // Reset while M1 is buffered: request dropped, never replayed
    M0HTRANS = IDL; M0HADDR = '0; M1HTRANS = NSQ; M1HADDR = 32'h1111_0000; HREADY = 1'b0;
    #2 chk("held capture M1HREADY", 100, 32'(M1HREADY), 32'(1));
    @(posedge HCLK);
    #1 M1HTRANS = IDL; M1HADDR = '0; M0HTRANS = NSQ; M0HADDR = 32'h2222_0000;
    #2 chk("held M1HREADY", 101, 32'(M1HREADY), 32'(0));
    chk("held HTRANS", 101, 32'(HTRANS), 32'(NSQ));
    chk("held HADDR", 101, HADDR, 32'h2222_0000);
    HRESETn = 1'b0;
    #1;
    chk("midrst M1HREADY", 102, 32'(M1HREADY), 32'(1));
    chk("midrst M0HREADY", 102, 32'(M0HREADY), 32'(0));
    chk("midrst HADDR", 102, HADDR, 32'h2222_0000);
    chk("midrst HGRANT", 102, 32'(HGRANT), 32'(0));
    @(posedge HCLK);
    #1 HRESETn = 1'b1; M0HTRANS = IDL; M0HADDR = '0; HREADY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("postrst HTRANS", 103 + c, 32'(HTRANS), 32'(IDL));
      chk("postrst HGRANT", 103 + c, 32'(HGRANT), 32'(0));
      chk("postrst M1HREADY", 103 + c, 32'(M1HREADY), 32'(1));
      @(posedge HCLK);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
